// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU types, PTE bit positions and the TLB fault check
package mmu_pkg;

  typedef logic [7:0] tlb_perm_bits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } tlb_state_e;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam int VPN_W = 36;  // vaddr[47:12]
  localparam int PPN_W = 52;  // paddr[63:12]

  // Any single violation makes the access fault; W without R is a reserved encoding.
  function automatic logic pte_fault(input tlb_perm_bits p, input logic wr, input logic ex,
                                     input logic usr);
    return !p[PTE_V] || (p[PTE_W] && !p[PTE_R]) || (wr && !p[PTE_W]) ||
           (ex && !p[PTE_X]) || (!wr && !ex && !p[PTE_R]) || (usr && !p[PTE_U]);
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// rtl/tlb_cam.sv - TLB tag store with fully-associative match
module tlb_cam
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [VPN_W-1:0]   wr_vpn_i,
  input  logic [VPN_W-1:0]   lookup_vpn_i,
  output logic [ENTRIES-1:0] valid_o,
  output logic [ENTRIES-1:0] hit_vec_o,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   idx;

  // Valid bits: reset and flush clear everything, a fill sets one entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag array; contents are meaningless while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      vpn_q[wr_idx_i] <= wr_vpn_i;
    end
  end

  // Parallel compare; the OR-encode is exact because duplicates are never installed.
  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (vpn_q[i] == lookup_vpn_i);
      if (match[i]) idx = idx | IDX_W'(i);
    end
  end

  assign valid_o   = valid_q;
  assign hit_vec_o = match;
  assign hit_o     = |match;
  assign hit_idx_o = idx;

endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - fully-associative TLB with walker interface; TLB_PERF_CNT_EN adds hit/miss counters
module tlb
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [63:0]        req_addr,
  input  logic               req_write,
  input  logic               req_exec,
  input  logic               req_user,
  output logic               resp_valid,
  output logic [63:0]        resp_paddr,
  output logic               resp_fault,
  output logic               mmu_req_valid,
  output logic [63:0]        mmu_req_addr,
  input  logic               mmu_resp_valid,
  input  logic [63:0]        mmu_resp_addr,
  input  logic [7:0]         mmu_resp_perms,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  localparam int IW = $clog2(ENTRIES);

  tlb_state_e         state_q, state_d;
  logic [63:0]        lat_addr_q;
  logic               lat_write_q, lat_exec_q, lat_user_q;
  logic               flush_seen_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  tlb_perm_bits       perms_q [ENTRIES];
  logic               resp_valid_q, resp_fault_q;
  logic [63:0]        resp_paddr_q;

  logic [ENTRIES-1:0] valid_vec, hit_vec;
  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic               free_found;
  logic [IW-1:0]      free_idx, victim_idx;
  logic               accept, miss, walk_done, install;
  logic               hit_fault, walk_fault;
  logic               unused_lsb;

  assign unused_lsb = ^{mmu_resp_addr[11:0], hit_vec};

  assign accept    = req_valid && req_ready;
  assign miss      = accept && en && !hit;
  assign walk_done = (state_q == WALK) && mmu_resp_valid;
  assign install   = walk_done && !flush && !flush_seen_q;

  tlb_cam #(.ENTRIES(ENTRIES), .IDX_W(IW)) u_cam (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .wr_en_i      (install),
    .wr_idx_i     (victim_idx),
    .wr_vpn_i     (lat_addr_q[47:12]),
    .lookup_vpn_i (req_addr[47:12]),
    .valid_o      (valid_vec),
    .hit_vec_o    (hit_vec),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx)
  );

  // Victim: lowest-index free slot, otherwise the round-robin pointer.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    victim_idx = free_found ? free_idx : rr_ptr_q;
  end

  assign hit_fault  = pte_fault(perms_q[hit_idx], req_write, req_exec, req_user);
  assign walk_fault = pte_fault(mmu_resp_perms, lat_write_q, lat_exec_q, lat_user_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: only a translated miss starts a walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = WALK;
      WALK:    if (mmu_resp_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready     = (state_q == IDLE) && !flush;
    mmu_req_valid = (state_q == WALK);
  end

  // Latch the missing request and remember a flush seen while the walk is outstanding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_addr_q   <= '0;
      lat_write_q  <= 1'b0;
      lat_exec_q   <= 1'b0;
      lat_user_q   <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      if (miss) begin
        lat_addr_q  <= req_addr;
        lat_write_q <= req_write;
        lat_exec_q  <= req_exec;
        lat_user_q  <= req_user;
      end
      flush_seen_q <= (state_d == WALK) && (flush || flush_seen_q);
    end
  end

  // Entry payload written on fill; gated by the cam valid bit.
  always_ff @(posedge clk) begin
    if (install) begin
      ppn_q[victim_idx]   <= mmu_resp_addr[63:12];
      perms_q[victim_idx] <= mmu_resp_perms;
    end
  end

  // Round-robin pointer advances only when a valid entry is evicted.
  always_ff @(posedge clk) begin
    if (!reset || flush)            rr_ptr_q <= '0;
    else if (install && !free_found) rr_ptr_q <= rr_ptr_q + 1'b1;
  end

  // Response register: bypass and hit answer the cycle after acceptance, a walk during RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_paddr_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept && !en) begin
        resp_valid_q <= 1'b1;
        resp_fault_q <= 1'b0;
        resp_paddr_q <= req_addr;
      end else if (accept && hit) begin
        resp_valid_q <= 1'b1;
        resp_fault_q <= hit_fault;
        resp_paddr_q <= hit_fault ? 64'd0 : {ppn_q[hit_idx], req_addr[11:0]};
      end else if (walk_done) begin
        resp_valid_q <= 1'b1;
        resp_fault_q <= walk_fault;
        resp_paddr_q <= walk_fault ? 64'd0 : {mmu_resp_addr[63:12], lat_addr_q[11:0]};
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_fault   = resp_fault_q;
  assign resp_paddr   = resp_paddr_q;
  assign mmu_req_addr = lat_addr_q;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating performance counters for translated lookups.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept && en && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != '1))               miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - directed self-checking bench for tlb
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_exec = 1'b0;
  logic        req_user = 1'b0;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  logic        mmu_req_valid;
  logic [63:0] mmu_req_addr;
  logic        mmu_resp_valid = 1'b0;
  logic [63:0] mmu_resp_addr = '0;
  logic [7:0]  mmu_resp_perms = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          total = 0;
  int          bad = 0;

  logic [63:0] r_paddr, r_mmu_addr;
  logic        r_fault, r_walked;
  int          r_lat;

  tlb #(.ENTRIES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_exec       (req_exec),
    .req_user       (req_user),
    .resp_valid     (resp_valid),
    .resp_paddr     (resp_paddr),
    .resp_fault     (resp_fault),
    .mmu_req_valid  (mmu_req_valid),
    .mmu_req_addr   (mmu_req_addr),
    .mmu_resp_valid (mmu_resp_valid),
    .mmu_resp_addr  (mmu_resp_addr),
    .mmu_resp_perms (mmu_resp_perms),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; a walker answers on its 3rd request cycle with wa/wp, optional flush on the 1st.
  task automatic access(input logic [63:0] a, input logic w, input logic x, input logic u,
                        input logic [63:0] wa, input logic [7:0] wp, input bit fl);
    int wc;
    bit done;
    @(negedge clk);
    req_addr = a; req_write = w; req_exec = x; req_user = u; req_valid = 1'b1;
    chk("req_ready", req_ready, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r_walked = 1'b0; r_mmu_addr = '0; r_lat = 0; r_paddr = '0; r_fault = 1'b0;
    done = 1'b0; wc = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      mmu_resp_valid = 1'b0;
      flush = 1'b0;
      if (resp_valid) begin
        done = 1'b1; r_lat = k; r_paddr = resp_paddr; r_fault = resp_fault;
      end else if (mmu_req_valid) begin
        r_walked = 1'b1; r_mmu_addr = mmu_req_addr; wc++;
        if (fl && wc == 1) flush = 1'b1;
        if (wc == 3) begin
          mmu_resp_valid = 1'b1; mmu_resp_addr = wa; mmu_resp_perms = wp;
        end
      end
    end
    chk("resp_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 64'd0);
    chk("rst_resp_fault", resp_fault, 64'd0);
    chk("rst_resp_paddr", resp_paddr, 64'd0);
    chk("rst_mmu_req_valid", mmu_req_valid, 64'd0);
    chk("rst_mmu_req_addr", mmu_req_addr, 64'd0);
    chk("rst_hit_count", hit_count, 64'd0);
    chk("rst_miss_count", miss_count, 64'd0);
    reset = 1'b1;

    // Cold miss
    access(64'h0000_4000_1234, 1'b0, 1'b0, 1'b0, 64'h8000_2000, 8'h0F, 1'b0);
    chk("cold_walked", r_walked, 64'd1);
    chk("cold_mmu_addr", r_mmu_addr, 64'h4000_1234);
    chk("cold_paddr", r_paddr, 64'h8000_2234);
    chk("cold_fault", r_fault, 64'd0);

    // Repeat hit on the same page
    access(64'h0000_4000_10AB, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("hit_walked", r_walked, 64'd0);
    chk("hit_latency", 64'(r_lat), 64'd1);
    chk("hit_paddr", r_paddr, 64'h8000_20AB);
    chk("hit_fault", r_fault, 64'd0);

    // Write to a page without W: faults, entry still installed
    access(64'h0000_5000_0000, 1'b1, 1'b0, 1'b0, 64'h9000_0000, 8'h0B, 1'b0);
    chk("wr_nw_walked", r_walked, 64'd1);
    chk("wr_nw_fault", r_fault, 64'd1);
    chk("wr_nw_paddr", r_paddr, 64'd0);
    access(64'h0000_5000_0010, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("rd_nw_walked", r_walked, 64'd0);
    chk("rd_nw_fault", r_fault, 64'd0);
    chk("rd_nw_paddr", r_paddr, 64'h9000_0010);

    // User fetch on a supervisor page
    access(64'h0000_4000_1000, 1'b0, 1'b1, 1'b1, 64'h0, 8'h00, 1'b0);
    chk("ufetch_walked", r_walked, 64'd0);
    chk("ufetch_fault", r_fault, 64'd1);
    chk("ufetch_paddr", r_paddr, 64'd0);

    // Back-to-back hits, one per cycle
    @(negedge clk);
    req_addr = 64'h0000_4000_1010; req_write = 1'b0; req_exec = 1'b0; req_user = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 64'h0000_4000_1020;
    @(negedge clk);
    chk("b2b_valid0", resp_valid, 64'd1);
    chk("b2b_paddr0", resp_paddr, 64'h8000_2010);
    chk("b2b_ready", req_ready, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", resp_valid, 64'd1);
    chk("b2b_paddr1", resp_paddr, 64'h8000_2020);
    @(negedge clk);
    chk("b2b_done", resp_valid, 64'd0);

    // Flush, then fill 9 pages into 8 entries
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      access(64'h0002_0000_0000 | (64'(p) << 12), 1'b0, 1'b0, 1'b0,
             64'hA000_0000 + (64'(p) << 12), 8'h0F, 1'b0);
      chk("fill_walked", r_walked, 64'd1);
    end
    access(64'h0002_0000_2040, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("repl_p2_walked", r_walked, 64'd0);
    chk("repl_p2_paddr", r_paddr, 64'hA000_2040);
    access(64'h0002_0000_9000, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    chk("repl_p9_walked", r_walked, 64'd0);
    chk("repl_p9_paddr", r_paddr, 64'hA000_9000);
    access(64'h0002_0000_1000, 1'b0, 1'b0, 1'b0, 64'hA000_1000, 8'h0F, 1'b0);
    chk("repl_p1_walked", r_walked, 64'd1);
    chk("repl_p1_paddr", r_paddr, 64'hA000_1000);

    // Flush while the walk is outstanding
    access(64'h0000_7000_0040, 1'b0, 1'b0, 1'b0, 64'hC000_0000, 8'h0F, 1'b1);
    chk("fwalk_walked", r_walked, 64'd1);
    chk("fwalk_paddr", r_paddr, 64'hC000_0040);
    chk("fwalk_fault", r_fault, 64'd0);
    access(64'h0000_7000_0040, 1'b0, 1'b0, 1'b0, 64'hC000_0000, 8'h0F, 1'b0);
    chk("fwalk_again_walked", r_walked, 64'd1);
    chk("fwalk_again_paddr", r_paddr, 64'hC000_0040);

    // Bypass
    en = 1'b0;
    access(64'h1234_5678, 1'b1, 1'b0, 1'b1, 64'h0, 8'h00, 1'b0);
    chk("byp_walked", r_walked, 64'd0);
    chk("byp_latency", 64'(r_lat), 64'd1);
    chk("byp_paddr", r_paddr, 64'h1234_5678);
    chk("byp_fault", r_fault, 64'd0);
    en = 1'b1;

`ifdef TLB_PERF_CNT_EN
    chk("hit_count", hit_count, 64'd7);
    chk("miss_count", miss_count, 64'd14);
`else
    chk("hit_count_tied", hit_count, 64'd0);
    chk("miss_count_tied", miss_count, 64'd0);
`endif

    // Reset in the middle of a walk
    access(64'h0000_6000_0000, 1'b0, 1'b0, 1'b0, 64'hD000_0000, 8'h0F, 1'b0);
    chk("pre_rst_walked", r_walked, 64'd1);
    @(negedge clk);
    req_addr = 64'h0000_B000_0000; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midwalk_mmu_valid", mmu_req_valid, 64'd1);
    chk("midwalk_mmu_addr", mmu_req_addr, 64'hB000_0000);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rstwalk_mmu_valid", mmu_req_valid, 64'd0);
    chk("rstwalk_mmu_addr", mmu_req_addr, 64'd0);
    chk("rstwalk_resp_valid", resp_valid, 64'd0);
    mmu_resp_valid = 1'b1; mmu_resp_addr = 64'hE000_0000; mmu_resp_perms = 8'h0F;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    chk("stale_walk_resp0", resp_valid, 64'd0);
    @(negedge clk);
    chk("stale_walk_resp1", resp_valid, 64'd0);
    chk("stale_walk_mmu", mmu_req_valid, 64'd0);
    access(64'h0000_6000_0000, 1'b0, 1'b0, 1'b0, 64'hD000_0000, 8'h0F, 1'b0);
    chk("post_rst_walked", r_walked, 64'd1);
    chk("post_rst_paddr", r_paddr, 64'hD000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
